xdbus_arbiter: RTL and testbench

//  Two-master round-robin arbiter for the Versat data bus (sel/we/addr/data).

---
 rtl/xdbus_arbiter_pkg.sv | 20 ++
 rtl/xdbus_arbiter_if.sv | 21 ++
 rtl/xdbus_arbiter.sv | 105 ++++++++++
 tb/tb_xdbus_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xdbus_arbiter_pkg.sv
// Shared types and defaults for the two-master Versat data-bus arbiter.
// The state encoding and hold-counter sizing live here so the RTL and any user agree on them.
package xdbus_arbiter_pkg;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 16;
  localparam int DEF_MAX_HOLD = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  // One spare bit above clog2 keeps MAX_HOLD=1 at a legal 1-bit width.
  function automatic int hold_w(input int max_hold);
    return $clog2(max_hold) + 1;
  endfunction

endpackage

// File: rtl/xdbus_arbiter_if.sv
// One master channel of the Versat data bus: request side driven by a master,
// grant/ack/read-data side driven by the arbiter.
interface xdbus_arbiter_if
  import xdbus_arbiter_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, ack, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, ack, rdata);

endinterface

// File: rtl/xdbus_arbiter.sv
// Two-master round-robin arbiter for the Versat data bus: registered grant,
// one access per cycle, one-cycle ack, and a bounded tenure under contention.
module xdbus_arbiter
  import xdbus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  xdbus_arbiter_if.slave     m0,
  xdbus_arbiter_if.slave     m1,
  output logic               s_sel,
  output logic               s_we,
  output logic [ADDR_W-1:0]  s_addr,
  output logic [DATA_W-1:0]  s_wdata,
  input  logic [DATA_W-1:0]  s_rdata
);

  localparam int               HOLD_W    = hold_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rr_last_q, rr_last_d;
  logic              ack0_q, ack1_q;
  logic              acc0, acc1;

  assign acc0 = (state_q == ARB_OWN0) & m0.req;
  assign acc1 = (state_q == ARB_OWN1) & m1.req;

  // rr_last resets to 1 so that master 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB_IDLE;
      hold_q    <= '0;
      rr_last_q <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      state_q   <= state_d;
      hold_q    <= hold_d;
      rr_last_q <= rr_last_d;
      ack0_q    <= acc0;
      ack1_q    <= acc1;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
    state_d   = state_q;
    hold_d    = hold_q;
    rr_last_d = rr_last_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (m0.req && m1.req) state_d = rr_last_q ? ARB_OWN0 : ARB_OWN1;
        else if (m0.req)      state_d = ARB_OWN0;
        else if (m1.req)      state_d = ARB_OWN1;
      end
      ARB_OWN0: begin
        if (!m0.req)                         state_d = m1.req ? ARB_OWN1 : ARB_IDLE;
        else if (m1.req && hold_q == HOLD_LAST) state_d = ARB_OWN1;
      end
      ARB_OWN1: begin
        if (!m1.req)                         state_d = m0.req ? ARB_OWN0 : ARB_IDLE;
        else if (m0.req && hold_q == HOLD_LAST) state_d = ARB_OWN0;
      end
      default: state_d = ARB_IDLE;
    endcase

    // Leaving IDLE has no previous owner, so rr_last only moves when an owner gives up the bus.
    if (state_d != state_q) begin
      hold_d = '0;
      if (state_q == ARB_OWN0)      rr_last_d = 1'b0;
      else if (state_q == ARB_OWN1) rr_last_d = 1'b1;
    end else if ((acc0 || acc1) && hold_q != HOLD_LAST) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_comb begin
    m0.gnt   = (state_q == ARB_OWN0);
    m1.gnt   = (state_q == ARB_OWN1);
    m0.ack   = ack0_q;
    m1.ack   = ack1_q;
    m0.rdata = ack0_q ? s_rdata : '0;
    m1.rdata = ack1_q ? s_rdata : '0;

    s_sel   = acc0 | acc1;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (acc0) begin
      s_we    = m0.we;
      s_addr  = m0.addr;
      s_wdata = m0.wdata;
    end else if (acc1) begin
      s_we    = m1.we;
      s_addr  = m1.addr;
      s_wdata = m1.wdata;
    end
  end

endmodule

// File: tb/tb_xdbus_arbiter.sv
// Bench for xdbus_arbiter: a tenure-level ownership model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_xdbus_arbiter;
  import xdbus_arbiter_pkg::*;

  localparam int          MAX_HOLD = 4;
  localparam logic [31:0] K        = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xdbus_arbiter_if m0_if ();
  xdbus_arbiter_if m1_if ();

  logic              s_sel, s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata, s_rdata;

  xdbus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_if),
    .m1      (m1_if),
    .s_sel   (s_sel),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata)
  );

  // Synchronous slave: read data appears one cycle after the select.
  always @(posedge clk or negedge rst) begin
    if (!rst) s_rdata <= '0;
    else      s_rdata <= s_sel ? (32'(s_addr) ^ K) : '0;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ownership model: who owns the bus, how many accesses this tenure, who owned last.
  int          own  = -1;
  int          tcnt = 0;
  int          last = 1;
  bit          pend [2];
  logic [31:0] prd  [2];

  always @(negedge clk) begin
    if (!rst) begin
      own = -1; tcnt = 0; last = 1; pend[0] = 0; pend[1] = 0;
      check("rst_gnt0", 32'(m0_if.gnt), 0);
      check("rst_gnt1", 32'(m1_if.gnt), 0);
      check("rst_ack",  32'(m0_if.ack | m1_if.ack), 0);
      check("rst_sel",  32'(s_sel), 0);
    end else begin
      bit r0, r1, a0, a1, mine, other;
      int nxt;
      logic [31:0] e_addr, e_wdata;
      logic        e_we;
      r0 = m0_if.req; r1 = m1_if.req;
      a0 = (own == 0) && r0;
      a1 = (own == 1) && r1;
      e_we = a0 ? m0_if.we : (a1 ? m1_if.we : 1'b0);
      e_addr = a0 ? 32'(m0_if.addr) : (a1 ? 32'(m1_if.addr) : 32'd0);
      e_wdata = a0 ? m0_if.wdata : (a1 ? m1_if.wdata : 32'd0);

      check("gnt0",   32'(m0_if.gnt), 32'(own == 0));
      check("gnt1",   32'(m1_if.gnt), 32'(own == 1));
      check("gnt_excl", 32'(m0_if.gnt & m1_if.gnt), 0);
      check("s_sel",  32'(s_sel), 32'(a0 | a1));
      check("s_we",   32'(s_we), 32'(e_we));
      check("s_addr", 32'(s_addr), e_addr);
      check("s_wdata", s_wdata, e_wdata);
      check("ack0",   32'(m0_if.ack), 32'(pend[0]));
      check("ack1",   32'(m1_if.ack), 32'(pend[1]));
      check("rdata0", m0_if.rdata, pend[0] ? prd[0] : 32'd0);
      check("rdata1", m1_if.rdata, pend[1] ? prd[1] : 32'd0);

      pend[0] = a0; prd[0] = 32'(m0_if.addr) ^ K;
      pend[1] = a1; prd[1] = 32'(m1_if.addr) ^ K;

      if (own == -1) begin
        if (r0 && r1)  nxt = (last == 0) ? 1 : 0;
        else if (r0)   nxt = 0;
        else if (r1)   nxt = 1;
        else           nxt = -1;
      end else begin
        mine  = (own == 0) ? r0 : r1;
        other = (own == 0) ? r1 : r0;
        if (mine) tcnt++;
        if (!mine)                          nxt = other ? 1 - own : -1;
        else if (other && tcnt >= MAX_HOLD) nxt = 1 - own;
        else                                nxt = own;
      end
      if (nxt != own) begin
        if (own != -1) last = own;
        tcnt = 0;
      end
      own = nxt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_if.req = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = '0;
  endtask

  int seq [17];
  int n0, n1, acc_n, ack_n, gaps;
  bit started, acc0_now, acc1_now;

  initial begin
    idle_all();
    #2 rst = 1'b0;
    #21 rst = 1'b1;

    // Tie after reset: m0 first, then m1 with no idle gap on the handoff.
    tick();
    m0_if.req = 1; m0_if.addr = 16'h20;
    m1_if.req = 1; m1_if.addr = 16'h30;
    @(negedge clk); check("t3_c0_gnt0", 32'(m0_if.gnt), 0);
    tick();
    @(negedge clk); check("t3_c1_gnt0", 32'(m0_if.gnt), 1);
                    check("t3_c1_gnt1", 32'(m1_if.gnt), 0);
    tick(); m0_if.req = 0;
    tick();
    @(negedge clk); check("t3_handoff_gnt1", 32'(m1_if.gnt), 1);
                    check("t3_handoff_sel",  32'(s_sel), 1);
    tick(); m1_if.req = 0;
    repeat (3) tick();

    // Single read by m0.
    m0_if.req = 1; m0_if.addr = 16'h10; m0_if.we = 0;
    tick();
    @(negedge clk); check("t1_gnt0",   32'(m0_if.gnt), 1);
                    check("t1_sel",    32'(s_sel), 1);
                    check("t1_addr",   32'(s_addr), 32'h10);
    tick(); m0_if.req = 0;
    @(negedge clk); check("t1_ack0",   32'(m0_if.ack), 1);
                    check("t1_rdata0", m0_if.rdata, 32'hA5A5_0010);
    repeat (2) tick();

    // Write by m1.
    m1_if.req = 1; m1_if.we = 1; m1_if.addr = 16'h3; m1_if.wdata = 32'hDEAD_BEEF;
    tick();
    @(negedge clk); check("t2_we",    32'(s_we), 1);
                    check("t2_wdata", s_wdata, 32'hDEAD_BEEF);
                    check("t2_addr",  32'(s_addr), 32'h3);
                    check("t2_gnt0",  32'(m0_if.gnt), 0);
    tick(); m1_if.req = 0; m1_if.we = 0;
    @(negedge clk); check("t2_ack1",  32'(m1_if.ack), 1);
                    check("t2_ack0",  32'(m0_if.ack), 0);
    repeat (2) tick();

    // Hold limit: both stream; expect 4 m0, 4 m1, 4 m0, 4 m1 after the grant cycle.
    m0_if.req = 1; m0_if.addr = 16'h100;
    m1_if.req = 1; m1_if.addr = 16'h200;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      acc0_now = m0_if.gnt & m0_if.req;
      acc1_now = m1_if.gnt & m1_if.req;
      seq[i] = !s_sel ? -1 : (m1_if.gnt ? 1 : 0);
      tick();
      if (acc0_now) m0_if.addr = m0_if.addr + 16'd1;
      if (acc1_now) m1_if.addr = m1_if.addr + 16'd1;
    end
    n0 = 0; n1 = 0;
    for (int i = 0; i < 17; i++) begin
      check($sformatf("t4_owner_%0d", i), 32'(seq[i]),
            32'((i == 0) ? -1 : (((i - 1) / 4) % 2)));
      if (seq[i] == 0) n0++;
      if (seq[i] == 1) n1++;
    end
    check("t4_m0_count", 32'(n0), 8);
    check("t4_m1_count", 32'(n1), 8);
    idle_all();
    repeat (3) tick();

    // Lone master m1: 20 accesses, never preempted.
    m1_if.req = 1; m1_if.addr = 16'h400;
    acc_n = 0; ack_n = 0; gaps = 0; started = 0;
    for (int i = 0; i < 60 && ack_n < 20; i++) begin
      @(negedge clk);
      acc1_now = m1_if.gnt & m1_if.req;
      if (acc1_now) acc_n++;
      if (m1_if.ack) ack_n++;
      if (started && m1_if.req && !m1_if.gnt) gaps++;
      if (m1_if.gnt) started = 1;
      tick();
      if (acc1_now) m1_if.addr = m1_if.addr + 16'd1;
      if (acc_n == 20) m1_if.req = 0;
    end
    check("t5_accesses", 32'(acc_n), 20);
    check("t5_acks",     32'(ack_n), 20);
    check("t5_gaps",     32'(gaps), 0);
    idle_all();
    repeat (2) tick();

    // Reset in the middle of an m0 access, then a tie must again go to m0.
    m0_if.req = 1; m0_if.addr = 16'h40;
    tick();
    #2 rst = 1'b0;
    #1;
    check("t6_gnt0_low", 32'(m0_if.gnt), 0);
    check("t6_sel_low",  32'(s_sel), 0);
    check("t6_ack0_low", 32'(m0_if.ack), 0);
    m0_if.req = 0;
    tick();
    check("t6_ack_dropped", 32'(m0_if.ack), 0);
    tick();
    m0_if.req = 1; m0_if.addr = 16'h50;
    m1_if.req = 1; m1_if.addr = 16'h60;
    #2 rst = 1'b1;
    tick();
    @(negedge clk); check("t6_tie_gnt0", 32'(m0_if.gnt), 1);
                    check("t6_tie_gnt1", 32'(m1_if.gnt), 0);
    tick(); m0_if.req = 0;
    tick();
    @(negedge clk); check("t6_handoff_gnt1", 32'(m1_if.gnt), 1);
    tick(); m1_if.req = 0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
